vector_addition_seq: RTL
========================

Name: vector_addition_seq

Overview:
- Sequential, area-scalable successor to the element-wise float32 vector adder.
- Adds or subtracts two VLEN-element IEEE-754 single-precision vectors, LANES elements per cycle, using LANES FloatingAddition instances that are time-multiplexed over ceil(VLEN/LANES) cycles.
- Start/done handshake.
- Sits in front of the NN layer datapath (bias add, residual add) where a fully parallel adder array is too large.

Parameters:
- VLEN, 4: number of 32-bit float elements per vector; must be >= 1.
- LANES, 2: number of FloatingAddition instances, i.e. elements processed per cycle; must satisfy 1 <= LANES <= VLEN.
- NCHUNK (localparam) = (VLEN + LANES - 1) / LANES: number of compute cycles per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when the block is idle or done.
- sub  input  1  0 = result = A + B; 1 = result = A - B; captured with start.
- A  input  32*VLEN  operand vector; element i at A[32*i +: 32]; captured with start.
- B  input  32*VLEN  operand vector; same layout; captured with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse: result is complete and valid.
- result  output  32*VLEN  result vector; same element layout; registered.

Behaviour:
- Reset, synchronous on clk while rst = 1:
  - state = IDLE, chunk index k = 0.
  - busy = 0, done = 0, result = 0.
  - Internal A/B/sub latches cleared.
  - Reset overrides start.
  - Reset asserted mid-operation aborts it: no done pulse, result = 0.
- States: IDLE, RUN, DONE. busy = (state == RUN). done = (state == DONE), registered.
- IDLE:
  - start = 1 at an edge: latch A, B, sub; k = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - For every lane j in 0..LANES-1 with element e = k*LANES + j < VLEN, write result[32*e +: 32] = FloatingAddition(Alat[e], Blat'[e]).
  - Blat'[e] is Blat[e] with bit 31 inverted when sub = 1. This also applies to NaN, inf and zero; their handling is inherited from FloatingAddition.
  - Lanes with e >= VLEN (tail of the last chunk when VLEN mod LANES != 0) write nothing. No out-of-range slice is ever addressed.
  - If k == NCHUNK-1, go to DONE; otherwise k = k + 1.
- DONE:
  - Lasts exactly one cycle (done = 1).
  - start = 1 at this edge: latch new operands and go to RUN with k = 0. This is the back-to-back issue case; there is no idle bubble.
  - Otherwise go to IDLE.
- start while in RUN is ignored. It is not queued.
- Operand changes on A/B/sub after capture have no effect on the operation in flight.
- Latency: start sampled at edge 0. Chunk k is written at edge k+1. done is high in the cycle after edge NCHUNK.
  - Throughput: one vector per NCHUNK+1 cycles.
- result:
  - Elements not yet written in the current operation hold their previous-operation values.
  - result is guaranteed fully valid only while done = 1. It then holds until the next operation's writes or reset.
- LANES == VLEN: NCHUNK = 1, so done follows start by 2 edges.
- VLEN == 1, LANES == 1: degenerate single-adder case; must behave identically.
- All arithmetic is combinational inside FloatingAddition. The adder outputs feed the result register directly. No additional rounding or width conversion.

Test Plan:
- VLEN=4, LANES=2, sub=0:
  - Stimulus: A = {3F800000, 40000000, 3F000000, BF800000}, B = {40000000, 3F800000, 3F000000, 3F800000} (element 0 first).
  - Required: done exactly 3 cycles after the start edge (NCHUNK=2); result = {40400000, 40400000, 3F800000, 00000000}; busy high for exactly 2 cycles.
- Same operands with sub=1:
  - Required: result = {BF800000, 3F800000, 00000000, C0000000}.
- VLEN=5, LANES=2 (tail chunk):
  - Stimulus: all A = 3F800000, all B = 3F000000.
  - Required: NCHUNK=3; done 4 cycles after start; all 5 elements = 3FC00000; no X/out-of-range writes.
- Back-to-back and ignored start:
  - Stimulus: start again while done = 1 with new operands.
  - Required: RUN entered the next cycle and a second done pulse 3 cycles later with the new results.
  - Stimulus: start pulsed during RUN.
  - Required: ignored; exactly one done pulse.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle at k=1 (VLEN=4, LANES=2).
  - Required: next cycle busy=0, done=0, result=0, state IDLE; no done pulse. A subsequent start produces a correct result.
- Operand isolation:
  - Stimulus: change A/B/sub one cycle after start.
  - Required: result equals the sum of the values captured at the start edge.

Source files
------------

// File: rtl/vector_addition_seq.sv
// Sequential float32 vector add/subtract. LANES adders are time-multiplexed
// over NCHUNK cycles; start/busy/done handshake with back-to-back issue.

// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormal inputs/outputs supported, NaN results returned as quiet 7FC00000.
module FloatingAddition (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap;
  logic [31:0] x, y;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_sh, m;
  logic [27:0] sum28;
  logic [4:0]  lz;
  logic [9:0]  e, sh;
  logic        inc;
  logic [24:0] m25;
  logic [31:0] res;

  // Align, add/subtract magnitudes, normalise, round, then override specials
  always_comb begin
    a_nan = (&a_i[30:23]) && (|a_i[22:0]);
    b_nan = (&b_i[30:23]) && (|b_i[22:0]);
    a_inf = (&a_i[30:23]) && !(|a_i[22:0]);
    b_inf = (&b_i[30:23]) && !(|b_i[22:0]);

    // x always carries the larger magnitude, so the difference is never negative
    swap = b_i[30:0] > a_i[30:0];
    x    = swap ? b_i : a_i;
    y    = swap ? a_i : b_i;
    ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx   = {|x[30:23], x[22:0], 3'b000};
    my   = {|y[30:23], y[22:0], 3'b000};
    d    = ex - ey;

    // Bits shifted past the guard/round positions fold into the sticky bit
    if (d >= 8'd27) begin
      my_sh = {26'd0, |my};
    end else begin
      my_sh = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
    end

    if (x[31] == y[31]) sum28 = {1'b0, mx} + {1'b0, my_sh};
    else                sum28 = {1'b0, mx} - {1'b0, my_sh};

    e  = {2'b00, ex};
    lz = '0;
    sh = '0;
    if (sum28[27]) begin
      m = sum28[27:1] | {26'd0, sum28[0]};
      e = e + 10'd1;
    end else begin
      m  = sum28[26:0];
      lz = 5'd27;
      for (int unsigned i = 0; i < 27; i++) begin
        if (m[i]) lz = 5'(26 - i);
      end
      // Left shift stops at the minimum exponent, leaving a subnormal
      sh = ({5'd0, lz} < (e - 10'd1)) ? {5'd0, lz} : (e - 10'd1);
      m  = m << sh;
      e  = e - sh;
      if (!m[26]) e = 10'd0;
    end

    inc = m[2] & (m[1] | m[0] | m[3]);
    m25 = {1'b0, m[26:3]} + {24'd0, inc};
    if (m25[24]) begin
      e   = e + 10'd1;
      m25 = m25 >> 1;
    end else if ((e == 10'd0) && m25[23]) begin
      e = 10'd1;
    end

    if (e >= 10'd255)        res = {x[31], 8'hFF, 23'd0};
    else if (m25 == 25'd0)   res = (x[31] == y[31]) ? {x[31], 31'd0} : 32'd0;
    else                     res = {x[31], e[7:0], m25[22:0]};

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) res = 32'h7FC0_0000;
    else if (a_inf)                                                  res = a_i;
    else if (b_inf)                                                  res = b_i;

    sum_o = res;
  end
endmodule

module vector_addition_seq #(
  parameter int VLEN  = 4,
  parameter int LANES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic [32*VLEN-1:0] A,
  input  logic [32*VLEN-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [32*VLEN-1:0] result
);
  localparam int NCHUNK = (VLEN + LANES - 1) / LANES;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [32*VLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic                 sub_q, sub_d;
  logic [32*LANES-1:0]  lane_a, lane_b, lane_sum;

  // Route the current chunk's latched operands onto the lanes; tail lanes idle at zero
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int unsigned i = 0; i < VLEN; i++) begin
      if (k_q == KW'(i / LANES)) begin
        lane_a[32*(i % LANES) +: 32] = a_q[32*i +: 32];
        lane_b[32*(i % LANES) +: 32] = b_q[32*i +: 32] ^ {sub_q, 31'd0};
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    FloatingAddition u_add (
      .a_i   (lane_a[32*j +: 32]),
      .b_i   (lane_b[32*j +: 32]),
      .sum_o (lane_sum[32*j +: 32])
    );
  end

  // Next-state, chunk counter, operand capture and result write-back
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < VLEN; i++) begin
          if (k_q == KW'(i / LANES)) result_d[32*i +: 32] = lane_sum[32*(i % LANES) +: 32];
        end
        if (k_q == KW'(NCHUNK - 1)) state_d = DONE;
        else                        k_d     = k_q + KW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule
